// File: rtl/data_memory.sv
// Word-addressed synchronous data memory for the pipeline MEM stage.
// One-cycle registered read with write-first forwarding, a zero-clear
// sequence after reset, and detection of illegal writes.
module data_memory #(
  parameter int unsigned DEPTH_WORDS    = 1024,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic        dmem_we,
  output logic [31:0] dmem_rdata,
  output logic        dmem_busy,
  output logic        dmem_fault,
  output logic [31:0] fault_addr,
  output logic [31:0] wr_count
);

  localparam int unsigned   AW       = $clog2(DEPTH_WORDS);
  localparam logic [32:0]   SPAN     = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] clr_idx;
  logic          fault_seen;

  // Decode of the current-cycle request
  logic [31:0]   off_p0;
  logic [AW-1:0] idx_p0;
  logic          in_range_p0;
  logic          aligned_p0;
  logic          commit_p0;
  logic          reject_p0;

  // Array write port, shared by the clear sequence and committed stores
  logic          mem_we;
  logic [AW-1:0] mem_widx;
  logic [31:0]   mem_wdata;

  // Address decode and write legality; offset wraps modulo 2^32 so
  // addresses below BASE_ADDR land far out of range
  always_comb begin
    off_p0      = dmem_addr - BASE_ADDR;
    in_range_p0 = ({1'b0, off_p0} < SPAN);
    aligned_p0  = (dmem_addr[1:0] == 2'b00);
    idx_p0      = off_p0[AW+1:2];
    commit_p0   = dmem_we && in_range_p0 && aligned_p0 && (state == READY);
    reject_p0   = dmem_we && !commit_p0;
  end

  // Select the single array write: clear sweep wins while in CLEAR
  always_comb begin
    mem_we    = 1'b0;
    mem_widx  = idx_p0;
    mem_wdata = dmem_wdata;
    if (!rst) begin
      if (state == CLEAR) begin
        mem_we    = 1'b1;
        mem_widx  = clr_idx;
        mem_wdata = '0;
      end else if (commit_p0) begin
        mem_we = 1'b1;
      end
    end
  end

  // Storage array; contents are only ever changed through the write port
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_widx] <= mem_wdata;
    end
  end

  // Next state: CLEAR finishes on the edge that writes the last word
  always_comb begin
    state_next = state;
    if ((state == CLEAR) && (clr_idx == LAST_IDX)) begin
      state_next = READY;
    end
  end

  // State register; reset restarts the clear sweep when enabled
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR_ON_RESET ? CLEAR : READY;
    end else begin
      state <= state_next;
    end
  end

  // Clear sweep pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_idx <= '0;
    end else if (state == CLEAR) begin
      clr_idx <= clr_idx + AW'(1);
    end
  end

  // Registered read: zero while clearing, forwarded store data on a
  // same-cycle commit, zero for out-of-range addresses
  always_ff @(posedge clk) begin
    if (rst) begin
      dmem_rdata <= '0;
    end else if (state == CLEAR) begin
      dmem_rdata <= '0;
    end else if (commit_p0) begin
      dmem_rdata <= dmem_wdata;
    end else if (in_range_p0) begin
      dmem_rdata <= mem[idx_p0];
    end else begin
      dmem_rdata <= '0;
    end
  end

  // Fault pulse and sticky capture of the first rejected address
  always_ff @(posedge clk) begin
    if (rst) begin
      dmem_fault <= 1'b0;
      fault_seen <= 1'b0;
      fault_addr <= '0;
    end else begin
      dmem_fault <= reject_p0;
      if (reject_p0 && !fault_seen) begin
        fault_seen <= 1'b1;
        fault_addr <= dmem_addr;
      end
    end
  end

  // Committed-write counter, free-running wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count <= '0;
    end else if (commit_p0) begin
      wr_count <= wr_count + 32'd1;
    end
  end

  assign dmem_busy = (state == CLEAR);

endmodule

// File: tb/tb_data_memory.sv
// Directed testbench for data_memory with DEPTH_WORDS=16, BASE_ADDR=0.
module tb_data_memory;

  localparam int unsigned DEPTH = 16;

  logic        clk;
  logic        rst;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_we;
  logic [31:0] dmem_rdata;
  logic        dmem_busy;
  logic        dmem_fault;
  logic [31:0] fault_addr;
  logic [31:0] wr_count;

  int checks;
  int errors;

  data_memory #(
    .DEPTH_WORDS   (DEPTH),
    .BASE_ADDR     (32'h0000_0000),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .dmem_addr (dmem_addr),
    .dmem_wdata(dmem_wdata),
    .dmem_we   (dmem_we),
    .dmem_rdata(dmem_rdata),
    .dmem_busy (dmem_busy),
    .dmem_fault(dmem_fault),
    .fault_addr(fault_addr),
    .wr_count  (wr_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Count edges until busy falls, bounded
  task automatic count_busy(output int n);
    n = 0;
    while (dmem_busy === 1'b1 && n < 200) begin
      step();
      n++;
    end
  endtask

  int n;

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    dmem_addr  = 32'h0;
    dmem_wdata = 32'h0;
    dmem_we    = 1'b0;
    step();
    step();

    // Reset state
    check("rst_rdata", dmem_rdata, 32'h0);
    check("rst_fault", {31'b0, dmem_fault}, 32'h0);
    check("rst_fault_addr", fault_addr, 32'h0);
    check("rst_wr_count", wr_count, 32'h0);
    check("rst_busy", {31'b0, dmem_busy}, 32'h1);

    // Clear sequence length
    rst = 1'b0;
    count_busy(n);
    check("busy_cycles", n, DEPTH);

    // Every word reads zero after the clear
    for (int i = 0; i < DEPTH; i++) begin
      dmem_addr = 32'(i * 4);
      step();
      check($sformatf("clear_word%0d", i), dmem_rdata, 32'h0);
    end

    // Write then read back
    dmem_we = 1'b1; dmem_addr = 32'h8; dmem_wdata = 32'hDEAD_BEEF;
    step();
    check("wr8_fwd", dmem_rdata, 32'hDEAD_BEEF);
    dmem_we = 1'b0; dmem_addr = 32'h8;
    step();
    check("rd8", dmem_rdata, 32'hDEAD_BEEF);
    check("wc1", wr_count, 32'd1);

    // Write-first on the same address
    dmem_we = 1'b1; dmem_addr = 32'h4; dmem_wdata = 32'h1234_5678;
    step();
    check("wr4_fwd", dmem_rdata, 32'h1234_5678);
    check("wc2", wr_count, 32'd2);

    // Last legal word
    dmem_we = 1'b1; dmem_addr = 32'h3C; dmem_wdata = 32'h0F0F_0F0F;
    step();
    dmem_we = 1'b0; dmem_addr = 32'h3C;
    step();
    check("rd_last", dmem_rdata, 32'h0F0F_0F0F);
    check("wc3", wr_count, 32'd3);

    // Misaligned write rejected; read of that address returns old word
    dmem_we = 1'b1; dmem_addr = 32'h6; dmem_wdata = 32'hFFFF_FFFF;
    step();
    check("mis_fault", {31'b0, dmem_fault}, 32'h1);
    check("mis_fault_addr", fault_addr, 32'h6);
    check("mis_rdata", dmem_rdata, 32'h1234_5678);

    // Out-of-range write rejected; first fault address stays
    dmem_we = 1'b1; dmem_addr = 32'h40; dmem_wdata = 32'h1111_1111;
    step();
    check("oor_fault", {31'b0, dmem_fault}, 32'h1);
    check("oor_fault_addr", fault_addr, 32'h6);
    check("oor_rdata", dmem_rdata, 32'h0);
    dmem_we = 1'b0; dmem_addr = 32'h4;
    step();
    check("fault_pulse_end", {31'b0, dmem_fault}, 32'h0);
    check("rd4_unchanged", dmem_rdata, 32'h1234_5678);
    dmem_addr = 32'h0;
    step();
    check("rd0_unchanged", dmem_rdata, 32'h0);
    check("wc_after_faults", wr_count, 32'd3);

    // Unaligned read returns containing word
    dmem_we = 1'b1; dmem_addr = 32'h8; dmem_wdata = 32'hA5A5_A5A5;
    step();
    dmem_we = 1'b0; dmem_addr = 32'hB;
    step();
    check("rdB", dmem_rdata, 32'hA5A5_A5A5);
    check("rdB_fault", {31'b0, dmem_fault}, 32'h0);
    check("wc4", wr_count, 32'd4);

    // Out-of-range reads
    dmem_addr = 32'h100;
    step();
    check("oor_rd", dmem_rdata, 32'h0);
    check("oor_rd_fault", {31'b0, dmem_fault}, 32'h0);
    dmem_addr = 32'hFFFF_FFFC;
    step();
    check("neg_rd", dmem_rdata, 32'h0);

    // Write during CLEAR, then reset in mid-clear
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst2_fault_addr", fault_addr, 32'h0);
    check("rst2_wc", wr_count, 32'h0);
    step();
    step();
    dmem_we = 1'b1; dmem_addr = 32'hC; dmem_wdata = 32'hCAFE_F00D;
    step();
    dmem_we = 1'b0; dmem_addr = 32'h0;
    check("clr_wr_fault", {31'b0, dmem_fault}, 32'h1);
    check("clr_wr_fault_addr", fault_addr, 32'hC);
    check("clr_wr_wc", wr_count, 32'h0);
    check("clr_rdata", dmem_rdata, 32'h0);
    check("clr_busy", {31'b0, dmem_busy}, 32'h1);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    count_busy(n);
    check("busy_cycles_restart", n, DEPTH);
    dmem_addr = 32'hC;
    step();
    check("rdC_cleared", dmem_rdata, 32'h0);
    dmem_addr = 32'h8;
    step();
    check("rd8_cleared", dmem_rdata, 32'h0);
    dmem_addr = 32'h3C;
    step();
    check("rd_last_cleared", dmem_rdata, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
